zx_kbd_map: RTL and testbench

- Parametrised successor to the fixed-map ZX keyboard decoder.
- Converts PS/2 set-2 scan codes into a ROWS x COLS active-low key matrix, read by the ULA through the address high byte.
- The PS/2-to-matrix mapping comes from a writable table, so there are no hardwired case arms. Each PS/2 key drives up to two matrix positions.
- Per-position hold counters stop a shared position (e.g. CAPS SHIFT) from being released early.
- Adds typematic filtering, Pause-sequence skipping, prefix timeout and release-all recovery.

---
 rtl/zx_kbd_map.sv | 202 ++++++++++++++++++++
 tb/tb_zx_kbd_map.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_kbd_map.sv
// PS/2 set-2 to ZX Spectrum key matrix decoder with a writable mapping table,
// per-position hold counters, typematic filtering, Pause skipping and prefix timeout.
module zx_kbd_map #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned COLS           = 5,
  parameter int unsigned CNT_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic [15:0]                         A,
  output logic [COLS-1:0]                     key_row,
  input  logic [7:0]                          scan_code,
  input  logic                                scan_code_ready,
  input  logic                                scan_code_error,
  input  logic                                release_all,
  input  logic                                map_we,
  input  logic [8:0]                          map_addr,
  input  logic [2*(4+$clog2(COLS))-1:0]       map_wdata,
  output logic                                pressed,
  output logic [8:0]                          held_keys
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned EntW = 4 + ColW;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SkW  = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  state_e                                 state_q, state_d;
  logic [SkW-1:0]                         skip_q, skip_d;
  logic [ToW-1:0]                         to_q, to_d;
  logic                                   ev_valid_q, ev_valid_d;
  logic                                   ev_make_q, ev_make_d;
  logic [8:0]                             ev_idx_q, ev_idx_d;
  logic [511:0]                           bitmap_q, bitmap_d;
  logic [8:0]                             held_q, held_d;
  logic [ROWS-1:0][COLS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*EntW-1:0]                      ent_q;
  logic [2*EntW-1:0]                      map_mem [512];

  logic clr;
  assign clr = scan_code_error | release_all | map_we;

  // Prefix decoder (stage 0)
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    to_d       = to_q;
    ev_valid_d = 1'b0;
    ev_make_d  = 1'b0;
    ev_idx_d   = {1'b0, scan_code};
    if (scan_code_ready) begin
      to_d = '0;
      unique case (state_q)
        StIdle: begin
          if (scan_code == 8'hE0) begin
            state_d = StExt;
          end else if (scan_code == 8'hF0) begin
            state_d = StBrk;
          end else if (scan_code == 8'hE1) begin
            if (PAUSE_SKIP != 0) state_d = StPause;
            skip_d = SkW'(PAUSE_SKIP);
          end else begin
            ev_valid_d = 1'b1;
            ev_make_d  = 1'b1;
          end
        end
        StExt: begin
          if (scan_code == 8'hF0) begin
            state_d = StExtBrk;
          end else if (scan_code != 8'hE0) begin
            ev_valid_d = 1'b1;
            ev_make_d  = 1'b1;
            ev_idx_d   = {1'b1, scan_code};
            state_d    = StIdle;
          end
        end
        StBrk: begin
          if (scan_code == 8'hE0) begin
            state_d = StExtBrk;
          end else begin
            ev_valid_d = 1'b1;
            state_d    = StIdle;
          end
        end
        StExtBrk: begin
          if (scan_code != 8'hE0 && scan_code != 8'hF0 && scan_code != 8'hE1) begin
            ev_valid_d = 1'b1;
            ev_idx_d   = {1'b1, scan_code};
            state_d    = StIdle;
          end
        end
        StPause: begin
          skip_d = skip_q - 1'b1;
          if (skip_q <= SkW'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_q == ToW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StIdle;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    if (clr) begin
      state_d    = StIdle;
      skip_d     = '0;
      to_d       = '0;
      ev_valid_d = 1'b0;
    end
  end

  // Event apply (stage 1): one update per matrix position even when both slots hit it
  logic [EntW-1:0] ent1, ent2;
  logic            do_inc, do_dec, hit;
  assign ent1   = ent_q[2*EntW-1:EntW];
  assign ent2   = ent_q[EntW-1:0];
  assign do_inc = ev_valid_q & ev_make_q & ~bitmap_q[ev_idx_q];
  assign do_dec = ev_valid_q & ~ev_make_q & bitmap_q[ev_idx_q];

  always_comb begin
    bitmap_d = bitmap_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    hit      = 1'b0;
    if (do_inc) begin
      bitmap_d[ev_idx_q] = 1'b1;
      held_d             = held_q + 9'd1;
    end else if (do_dec) begin
      bitmap_d[ev_idx_q] = 1'b0;
      held_d             = held_q - 9'd1;
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        hit = (ent1[EntW-1] && ent1[EntW-2 -: 3] == 3'(r) && ent1[ColW-1:0] == ColW'(c)) ||
              (ent2[EntW-1] && ent2[EntW-2 -: 3] == 3'(r) && ent2[ColW-1:0] == ColW'(c));
        if (hit && do_inc && cnt_q[r][c] != CntMax) cnt_d[r][c] = cnt_q[r][c] + 1'b1;
        if (hit && do_dec && cnt_q[r][c] != '0)     cnt_d[r][c] = cnt_q[r][c] - 1'b1;
      end
    end
    if (clr) begin
      bitmap_d = '0;
      held_d   = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      to_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_make_q  <= 1'b0;
      ev_idx_q   <= '0;
      bitmap_q   <= '0;
      held_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      to_q       <= to_d;
      ev_valid_q <= ev_valid_d;
      ev_make_q  <= ev_make_d;
      ev_idx_q   <= ev_idx_d;
      bitmap_q   <= bitmap_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
    end
  end

  // Table is software-loaded and deliberately not reset
  always_ff @(posedge clk) begin
    if (map_we) map_mem[map_addr] <= map_wdata;
    ent_q <= map_mem[ev_idx_d];
  end

  always_comb begin
    key_row = '1;
    pressed = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (cnt_q[r][c] != '0) begin
          pressed = 1'b1;
          if (!A[8+r]) key_row[c] = 1'b0;
        end
      end
    end
  end

  assign held_keys = held_q;

  logic unused_addr;
  assign unused_addr = ^A[7:0];

endmodule

// File: tb/tb_zx_kbd_map.sv
// Self-checking bench for zx_kbd_map: directed scenarios plus randomized traffic
// checked against a byte-stream/key-set reference model.
module tb_zx_kbd_map;
  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int TO    = 40;
  localparam int PSKIP = 7;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] A;
  logic [4:0]  key_row;
  logic [7:0]  scan_code;
  logic        scan_code_ready, scan_code_error, release_all, map_we;
  logic [8:0]  map_addr;
  logic [13:0] map_wdata;
  logic        pressed;
  logic [8:0]  held_keys;

  always #5 clk = ~clk;

  zx_kbd_map #(
    .ROWS(ROWS), .COLS(COLS), .CNT_W(2), .TIMEOUT_CYCLES(TO), .PAUSE_SKIP(PSKIP)
  ) dut (
    .clk(clk), .nreset(nreset), .A(A), .key_row(key_row), .scan_code(scan_code),
    .scan_code_ready(scan_code_ready), .scan_code_error(scan_code_error),
    .release_all(release_all), .map_we(map_we), .map_addr(map_addr),
    .map_wdata(map_wdata), .pressed(pressed), .held_keys(held_keys)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: set of keys down, saturating hold count per position
  logic [13:0] m_map [512];
  bit          m_down [512];
  int          m_held;
  int          m_cnt [ROWS][COLS];
  bit          m_ext, m_brk;
  int          m_skip;

  function automatic logic [13:0] ent(bit v1, int r1, int c1, bit v2, int r2, int c2);
    return {v1, 3'(r1), 3'(c1), v2, 3'(r2), 3'(c2)};
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 512; i++) m_down[i] = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_cnt[r][c] = 0;
    m_held = 0; m_ext = 0; m_brk = 0; m_skip = 0;
  endfunction

  function automatic void m_touch(int r, int c, bit inc);
    if (r < ROWS && c < COLS) begin
      if (inc) m_cnt[r][c] = (m_cnt[r][c] < 3) ? m_cnt[r][c] + 1 : 3;
      else     m_cnt[r][c] = (m_cnt[r][c] > 0) ? m_cnt[r][c] - 1 : 0;
    end
  endfunction

  function automatic void m_event(int idx, bit make);
    logic [13:0] e;
    e = m_map[idx];
    if (make == m_down[idx]) return;
    m_down[idx] = make;
    m_held += make ? 1 : -1;
    if (e[13]) m_touch(int'(e[12:10]), int'(e[9:7]), make);
    if (e[6] && !(e[13] && e[12:7] == e[5:0])) m_touch(int'(e[5:3]), int'(e[2:0]), make);
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk && b == 8'hE1) begin
      m_skip = PSKIP;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if ((b == 8'hF0 || b == 8'hE1) && m_ext && m_brk) begin
      m_brk = 1;
    end else begin
      m_event(int'({m_ext, b}), !m_brk);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [4:0] exp_row(logic [15:0] a);
    logic [4:0] k;
    k = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!a[8+r] && m_cnt[r][c] > 0) k[c] = 1'b0;
    return k;
  endfunction

  function automatic logic m_pressed();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_cnt[r][c] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code = b; scan_code_ready = 1; scan_code_error = 0; release_all = 0; map_we = 0;
    m_byte(b);
  endtask

  task automatic settle();
    @(negedge clk);
    scan_code_ready = 0; scan_code_error = 0; release_all = 0; map_we = 0;
    @(negedge clk);
  endtask

  task automatic load_entry(input int idx, input logic [13:0] val);
    @(negedge clk);
    map_we = 1; map_addr = 9'(idx); map_wdata = val; scan_code_ready = 0;
    m_map[idx] = val;
    m_clear();
  endtask

  task automatic test_reset();
    nreset = 0; A = 16'h0000; scan_code = 0; scan_code_ready = 0; scan_code_error = 0;
    release_all = 0; map_we = 0; map_addr = 0; map_wdata = 0;
    m_clear();
    repeat (3) @(negedge clk);
    nreset = 1;
    @(negedge clk); #1;
    n_cmp++; if (key_row !== 5'h1F) begin n_fail++; $display("FAIL reset_row got %b want 11111", key_row); end
    n_cmp++; if (pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed got %b want 0", pressed); end
    n_cmp++; if (held_keys !== 9'd0) begin n_fail++; $display("FAIL reset_held got %0d want 0", held_keys); end
  endtask

  task automatic init_table();
    for (int i = 0; i < 512; i++) load_entry(i, 14'h0);
    load_entry(9'h01A, ent(1, 0, 1, 0, 0, 0));
    load_entry(9'h076, ent(1, 0, 0, 1, 7, 0));
    load_entry(9'h014, ent(1, 0, 0, 0, 0, 0));
    load_entry(9'h066, ent(1, 0, 0, 1, 4, 0));
    load_entry(9'h06B, ent(1, 2, 3, 0, 0, 0));
    load_entry(9'h16B, ent(1, 3, 3, 0, 0, 0));
    settle();
  endtask

  task automatic test_basic();
    drive_byte(8'h1A); settle();
    A = 16'hFEFF; #1;
    n_cmp++; if (key_row !== 5'b11101) begin n_fail++; $display("FAIL basic_make got %b want 11101", key_row); end
    n_cmp++; if (pressed !== 1'b1) begin n_fail++; $display("FAIL basic_pressed got %b want 1", pressed); end
    drive_byte(8'hF0); drive_byte(8'h1A); settle(); #1;
    n_cmp++; if (key_row !== 5'b11111) begin n_fail++; $display("FAIL basic_break got %b want 11111", key_row); end
    drive_byte(8'h76); settle();
    A = 16'hFEFF; #1;
    n_cmp++; if (key_row !== 5'b11110) begin n_fail++; $display("FAIL dual_row0 got %b want 11110", key_row); end
    A = 16'h7FFF; #1;
    n_cmp++; if (key_row !== 5'b11110) begin n_fail++; $display("FAIL dual_row7 got %b want 11110", key_row); end
    A = 16'hFDFF; #1;
    n_cmp++; if (key_row !== 5'b11111) begin n_fail++; $display("FAIL dual_row1 got %b want 11111", key_row); end
    drive_byte(8'hF0); drive_byte(8'h76); settle(); #1;
    n_cmp++; if (held_keys !== 9'd0) begin n_fail++; $display("FAIL dual_held got %0d want 0", held_keys); end
  endtask

  task automatic test_shared();
    A = 16'hFEFF;
    drive_byte(8'h14); settle(); #1;
    n_cmp++; if (held_keys !== 9'd1) begin n_fail++; $display("FAIL shared_held1 got %0d want 1", held_keys); end
    drive_byte(8'h66); settle(); #1;
    n_cmp++; if (held_keys !== 9'd2) begin n_fail++; $display("FAIL shared_held2 got %0d want 2", held_keys); end
    drive_byte(8'hF0); drive_byte(8'h66); settle(); #1;
    n_cmp++; if (held_keys !== 9'd1) begin n_fail++; $display("FAIL shared_held3 got %0d want 1", held_keys); end
    n_cmp++; if (key_row[0] !== 1'b0) begin n_fail++; $display("FAIL shared_kept got %b want 0", key_row[0]); end
    A = 16'hEFFF; #1;
    n_cmp++; if (key_row !== 5'b11111) begin n_fail++; $display("FAIL shared_row4 got %b want 11111", key_row); end
    drive_byte(8'hF0); drive_byte(8'h14); settle(); #1;
    n_cmp++; if (pressed !== 1'b0) begin n_fail++; $display("FAIL shared_end got %b want 0", pressed); end
  endtask

  task automatic test_typematic();
    drive_byte(8'h1A); drive_byte(8'h1A); drive_byte(8'h1A); settle();
    A = 16'hFEFF; #1;
    n_cmp++; if (held_keys !== 9'd1) begin n_fail++; $display("FAIL typ_held got %0d want 1", held_keys); end
    n_cmp++; if (key_row !== 5'b11101) begin n_fail++; $display("FAIL typ_row got %b want 11101", key_row); end
    drive_byte(8'hF0); drive_byte(8'h1A); settle(); #1;
    n_cmp++; if (held_keys !== 9'd0) begin n_fail++; $display("FAIL typ_held0 got %0d want 0", held_keys); end
    n_cmp++; if (pressed !== 1'b0) begin n_fail++; $display("FAIL typ_pressed got %b want 0", pressed); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      drive_byte(seq[i]); settle();
      A = 16'h0000; #1;
      n_cmp++;
      if (key_row !== 5'h1F || held_keys !== 9'd0) begin
        n_fail++;
        $display("FAIL pause_byte%0d got row %b held %0d want 11111 held 0", i, key_row, held_keys);
      end
    end
    drive_byte(8'h1A); settle();
    A = 16'hFEFF; #1;
    n_cmp++; if (key_row !== 5'b11101) begin n_fail++; $display("FAIL pause_after got %b want 11101", key_row); end
    drive_byte(8'hF0); drive_byte(8'h1A); settle();
  endtask

  task automatic test_timeout();
    drive_byte(8'hE0); settle();
    repeat (TO + 5) @(negedge clk);
    m_ext = 0; m_brk = 0;
    drive_byte(8'h6B); settle();
    A = 16'hFBFF; #1;
    n_cmp++; if (key_row !== 5'b10111) begin n_fail++; $display("FAIL timeout_plain got %b want 10111", key_row); end
    A = 16'hF7FF; #1;
    n_cmp++; if (key_row !== 5'b11111) begin n_fail++; $display("FAIL timeout_ext got %b want 11111", key_row); end
    drive_byte(8'hF0); drive_byte(8'h6B); settle(); #1;
    n_cmp++; if (held_keys !== 9'd0) begin n_fail++; $display("FAIL timeout_rel got %0d want 0", held_keys); end
    // Gap shorter than the timeout keeps the extended prefix
    drive_byte(8'hE0); settle(); repeat (5) @(negedge clk);
    drive_byte(8'h6B); settle();
    A = 16'hF7FF; #1;
    n_cmp++; if (key_row !== 5'b10111) begin n_fail++; $display("FAIL short_gap got %b want 10111", key_row); end
    drive_byte(8'hE0); drive_byte(8'hF0); drive_byte(8'h6B); settle(); #1;
    n_cmp++; if (pressed !== 1'b0) begin n_fail++; $display("FAIL short_rel got %b want 0", pressed); end
  endtask

  task automatic test_error();
    drive_byte(8'h1A); drive_byte(8'h14); drive_byte(8'h6B); settle(); #1;
    n_cmp++; if (held_keys !== 9'd3) begin n_fail++; $display("FAIL err_pre got %0d want 3", held_keys); end
    @(negedge clk);
    scan_code = 8'h76; scan_code_ready = 1; scan_code_error = 1;
    m_clear();
    @(negedge clk);
    scan_code_ready = 0; scan_code_error = 0;
    A = 16'h0000; #1;
    n_cmp++; if (key_row !== 5'h1F) begin n_fail++; $display("FAIL err_row got %b want 11111", key_row); end
    n_cmp++; if (pressed !== 1'b0) begin n_fail++; $display("FAIL err_pressed got %b want 0", pressed); end
    n_cmp++; if (held_keys !== 9'd0) begin n_fail++; $display("FAIL err_held got %0d want 0", held_keys); end
    repeat (2) @(negedge clk);
    A = 16'h7FFF; #1;
    n_cmp++; if (key_row !== 5'h1F || held_keys !== 9'd0) begin
      n_fail++; $display("FAIL err_lost got row %b held %0d want 11111 held 0", key_row, held_keys);
    end
  endtask

  task automatic test_random();
    logic [7:0]  pool_code [16];
    bit          pool_ext  [16];
    int          k;
    bit          mk;
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin
      pool_code[i] = 8'($urandom_range(1, 127));
      pool_ext[i]  = 1'($urandom_range(0, 1));
      load_entry(int'({pool_ext[i], pool_code[i]}), 14'($urandom));
    end
    settle();
    drive_byte(8'h1A); settle();
    load_entry(9'h1FF, 14'h0); settle(); #1;
    n_cmp++; if (pressed !== 1'b0 || held_keys !== 9'd0) begin
      n_fail++; $display("FAIL mapwe_clear got pressed %b held %0d want 0 0", pressed, held_keys);
    end
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        release_all = 1; scan_code_ready = 0;
        m_clear();
      end else begin
        k  = $urandom_range(0, 15);
        mk = 1'($urandom_range(0, 1));
        if (pool_ext[k]) drive_byte(8'hE0);
        if (!mk) drive_byte(8'hF0);
        drive_byte(pool_code[k]);
        if ($urandom_range(0, 2) == 0) continue;
      end
      settle();
      a = 16'($urandom);
      A = a; #1;
      n_cmp++; if (key_row !== exp_row(a) || pressed !== m_pressed() || held_keys !== 9'(m_held)) begin
        n_fail++;
        $display("FAIL rand_%0d got row %b pr %b held %0d want row %b pr %b held %0d", it,
                 key_row, pressed, held_keys, exp_row(a), m_pressed(), m_held);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    init_table();
    test_basic();
    test_shared();
    test_typematic();
    test_pause();
    test_timeout();
    test_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
